sequenciador_programa: RTL and testbench

- Program sequencer that sits in front of the processor control unit and datapath.
- Fetches 9-bit instruction words (opcode III, Rx XXX, Ry YYY) from the instruction memory, presents them on DIN and pulses Run.
- Waits for Done, then advances the program counter.
- For mvi (opcode 001) it also fetches the immediate word and switches DIN to it from the processor's T1 onward.
- Provides start/pause/halt control, an instruction counter and a Done watchdog.

---
 rtl/sequenciador_programa_if.sv | 15 +
 rtl/sequenciador_programa.sv | 153 +++++++++++++++
 tb/tb_sequenciador_programa.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_programa_if.sv
// Sequencer bus: instruction-memory read port plus the DIN/Run/Done handshake
// towards the processor control unit.
interface sequenciador_programa_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRd;
  logic [8:0]        MemData;
  logic [8:0]        DIN;
  logic              Run;
  logic              Done;

  modport master (output MemAddr, MemRd, DIN, Run, input MemData, Done);
  modport slave  (input MemAddr, MemRd, DIN, Run, output MemData, Done);
endinterface

// File: rtl/sequenciador_programa.sv
// Program sequencer: fetches instructions (and mvi immediates), issues them to the
// processor with a Run pulse, advances the PC on Done, and guards Done with a watchdog.
module sequenciador_programa #(
  parameter int ADDR_W   = 5,
  parameter int END_ADDR = 31,
  parameter int TIMEOUT  = 8
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    Start,
  input  logic                    Pause,
  sequenciador_programa_if.master bus,
  output logic                    Busy,
  output logic                    Halted,
  output logic                    Error,
  output logic [7:0]              InstrCount
);
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] END_EXT = (ADDR_W+1)'(END_ADDR);
  localparam logic [2:0]      OP_MVI  = 3'b001;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_FETCH_IMM, S_LATCH_IMM, S_ISSUE,
    S_EXEC_T0, S_EXEC, S_ADVANCE, S_HALTED, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [8:0]        instr_q, instr_d;
  logic [8:0]        imm_q, imm_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [8:0]        din_q, din_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;
  logic              cur_mvi, nxt_mvi;
  logic [ADDR_W:0]   last_addr;

  assign cur_mvi   = instr_q[8:6] == OP_MVI;
  assign nxt_mvi   = instr_d[8:6] == OP_MVI;
  // Last address occupied by the current instruction; one extra bit so PC+1 cannot wrap.
  assign last_addr = {1'b0, pc_q} + {{ADDR_W{1'b0}}, cur_mvi};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:      if (Start) state_d = S_FETCH;
      S_FETCH:     state_d = S_LATCH;
      S_LATCH: begin
        instr_d = bus.MemData;
        state_d = (bus.MemData[8:6] == OP_MVI) ? S_FETCH_IMM : S_ISSUE;
      end
      S_FETCH_IMM: state_d = ({1'b0, pc_q} == END_EXT) ? S_ERROR : S_LATCH_IMM;
      S_LATCH_IMM: begin
        imm_d   = bus.MemData;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_EXEC_T0;
      end
      S_EXEC_T0:   state_d = S_EXEC;
      S_EXEC: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.Done)                      state_d = S_ADVANCE;
        else if (wd_d >= WD_W'(TIMEOUT))   state_d = S_ERROR;
      end
      S_ADVANCE: begin
        pc_d = pc_q + (cur_mvi ? ADDR_W'(2) : ADDR_W'(1));
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (last_addr >= END_EXT) state_d = S_HALTED;
        else if (Pause)           state_d = S_IDLE;
        else                      state_d = S_FETCH;
      end
      S_HALTED: begin
        if (Start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet track state_q.
  always_comb begin
    mem_rd_d   = (state_d == S_FETCH) ||
                 (state_d == S_FETCH_IMM && {1'b0, pc_d} != END_EXT);
    mem_addr_d = (state_d == S_FETCH_IMM) ? pc_d + ADDR_W'(1) : pc_d;
    run_d      = state_d == S_ISSUE;
    din_d      = '0;
    case (state_d)
      S_ISSUE, S_EXEC_T0: din_d = instr_d;
      S_EXEC:             din_d = nxt_mvi ? imm_d : instr_d;
      default:            din_d = '0;
    endcase
    busy_d   = !(state_d inside {S_IDLE, S_HALTED, S_ERROR});
    halted_d = state_d == S_HALTED;
    error_d  = state_d == S_ERROR;
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      wd_q       <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      din_q      <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      din_q      <= din_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      error_q    <= error_d;
    end
  end

  assign bus.MemAddr = mem_addr_q;
  assign bus.MemRd   = mem_rd_q;
  assign bus.DIN     = din_q;
  assign bus.Run     = run_q;
  assign Busy        = busy_q;
  assign Halted      = halted_q;
  assign Error       = error_q;
  assign InstrCount  = cnt_q;
endmodule

// File: tb/tb_sequenciador_programa.sv
// Bench for sequenciador_programa: memory + control-unit model, per-instruction DIN
// scoreboard and fetch-address scoreboard, one task per scenario.
module tb_sequenciador_programa;
  logic       Clock = 1'b0;
  logic       Resetn = 1'b1;
  logic       Start = 1'b0, Pause = 1'b0;
  logic       Start31 = 1'b0, Pause31 = 1'b0;
  logic       Busy, Halted, Error, Busy31, Halted31, Error31;
  logic [7:0] InstrCount, InstrCount31;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  sequenciador_programa_if #(.ADDR_W(5)) bus ();
  sequenciador_programa_if #(.ADDR_W(5)) bus31 ();

  sequenciador_programa #(.ADDR_W(5), .END_ADDR(2), .TIMEOUT(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Pause(Pause), .bus(bus.master),
    .Busy(Busy), .Halted(Halted), .Error(Error), .InstrCount(InstrCount));

  sequenciador_programa #(.ADDR_W(5), .END_ADDR(31), .TIMEOUT(8)) dut31 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start31), .Pause(Pause31), .bus(bus31.master),
    .Busy(Busy31), .Halted(Halted31), .Error(Error31), .InstrCount(InstrCount31));

  // Memory: registered read, data valid the cycle after MemRd.
  logic [8:0] mem   [0:31];
  logic [8:0] mem31 [0:31];
  always @(posedge Clock) if (bus.MemRd)   bus.MemData   <= mem[bus.MemAddr];
  always @(posedge Clock) if (bus31.MemRd) bus31.MemData <= mem31[bus31.MemAddr];

  // Control unit: Done a fixed number of cycles after Run.
  logic [15:0] run_sr = '0;
  logic [2:0]  run31_sr = '0;
  int          done_lat = 4;
  bit          done_en = 1'b1;
  always @(posedge Clock) run_sr   <= {run_sr[14:0], bus.Run};
  always @(posedge Clock) run31_sr <= {run31_sr[1:0], bus31.Run};
  assign bus.Done   = done_en && run_sr[done_lat-1];
  assign bus31.Done = run31_sr[2];

  typedef struct packed { logic [8:0] issue, t0, ex; } run_t;
  run_t       exp_q[$], obs_q[$];
  logic [4:0] exp_addr[$], addr_q[$];
  run_t       cur;
  int         ph = 0;
  int         runs31 = 0;

  always @(negedge Clock) begin
    if (bus.MemRd) addr_q.push_back(bus.MemAddr);
    if (bus.Run) begin cur.issue = bus.DIN; ph = 1; end
    else if (!Busy) ph = 0;
    else if (ph == 1) begin cur.t0 = bus.DIN; ph = 2; end
    else if (ph == 2) begin cur.ex = bus.DIN; obs_q.push_back(cur); ph = 0; end
    if (bus31.Run) runs31++;
  end

  task automatic do_reset();
    Resetn = 1'b1; Start = 1'b0; Pause = 1'b0; Start31 = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b0;
    exp_q.delete(); obs_q.delete(); exp_addr.delete(); addr_q.delete();
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic load_prog1();
    mem[0] = 9'h00A; mem[1] = 9'h09C; mem[2] = 9'h0C1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.MemAddr, bus.MemRd, bus.DIN, bus.Run, Busy, Halted, Error, InstrCount} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h rd=%b din=%h run=%b busy=%b halt=%b err=%b cnt=%0d exp all 0",
               bus.MemAddr, bus.MemRd, bus.DIN, bus.Run, Busy, Halted, Error, InstrCount);
    end
    repeat (3) @(negedge Clock);
    checks++;
    if (Busy !== 1'b0 || bus.MemRd !== 1'b0) begin
      errors++; $display("FAIL idle_without_start got busy=%b rd=%b exp 0 0", Busy, bus.MemRd);
    end
  endtask

  task automatic test_program();
    int n;
    do_reset(); load_prog1(); done_en = 1'b1; done_lat = 4;
    exp_q.push_back({9'h00A, 9'h00A, 9'h00A});
    exp_q.push_back({9'h09C, 9'h09C, 9'h09C});
    exp_q.push_back({9'h0C1, 9'h0C1, 9'h0C1});
    pulse_start();
    n = 0;
    while (!(Halted || Error) && n < 200) begin @(negedge Clock); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL prog_wait_halt got timeout exp Halted"); end
    while (exp_q.size() > 0) begin
      run_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 27'h7FFFFFF;
      checks++;
      if (o !== e) begin errors++; $display("FAIL prog_din got %h exp %h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL prog_extra_runs got %0d exp 0", obs_q.size()); end
    checks++;
    if ({Halted, Error, Busy, InstrCount, bus.DIN} !== {1'b1, 1'b0, 1'b0, 8'd3, 9'd0}) begin
      errors++;
      $display("FAIL prog_final got halt=%b err=%b busy=%b cnt=%0d din=%h exp 1 0 0 3 000",
               Halted, Error, Busy, InstrCount, bus.DIN);
    end
    pulse_start();
    checks++;
    if ({Halted, InstrCount, bus.MemRd, bus.MemAddr} !== {1'b0, 8'd0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL halt_restart got halt=%b cnt=%0d rd=%b addr=%0d exp 0 0 1 0",
               Halted, InstrCount, bus.MemRd, bus.MemAddr);
    end
  endtask

  task automatic test_mvi();
    int n;
    do_reset(); done_en = 1'b1; done_lat = 4;
    mem[0] = 9'h068; mem[1] = 9'h1A5; mem[2] = 9'h00A;
    exp_q.push_back({9'h068, 9'h068, 9'h1A5});
    exp_q.push_back({9'h00A, 9'h00A, 9'h00A});
    exp_addr.push_back(5'd0); exp_addr.push_back(5'd1); exp_addr.push_back(5'd2);
    pulse_start();
    n = 0;
    while (!(Halted || Error) && n < 200) begin @(negedge Clock); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL mvi_wait_halt got timeout exp Halted"); end
    while (exp_q.size() > 0) begin
      run_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 27'h7FFFFFF;
      checks++;
      if (o !== e) begin errors++; $display("FAIL mvi_din got %h exp %h", o, e); end
    end
    while (exp_addr.size() > 0) begin
      logic [4:0] ea, oa;
      ea = exp_addr.pop_front();
      oa = (addr_q.size() > 0) ? addr_q.pop_front() : 5'h1F;
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL mvi_fetch_addr got %0d exp %0d", oa, ea); end
    end
    checks++;
    if (InstrCount !== 8'd2 || Halted !== 1'b1) begin
      errors++; $display("FAIL mvi_count got cnt=%0d halt=%b exp 2 1", InstrCount, Halted);
    end
  endtask

  task automatic test_pause();
    int n, nr;
    do_reset(); load_prog1(); done_en = 1'b1; done_lat = 4;
    exp_addr.push_back(5'd0); exp_addr.push_back(5'd1);
    pulse_start();
    n = 0; nr = 0;
    while (nr < 2 && n < 200) begin @(negedge Clock); n++; if (bus.Run) nr++; end
    Pause = 1'b1;
    n = 0;
    while (Busy && n < 50) begin @(negedge Clock); n++; end
    Pause = 1'b0;
    checks++;
    if (n >= 50) begin errors++; $display("FAIL pause_wait got timeout exp Busy=0"); end
    checks++;
    if ({Busy, Halted, Error, InstrCount} !== {1'b0, 1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL pause_state got busy=%b halt=%b err=%b cnt=%0d exp 0 0 0 2", Busy, Halted, Error, InstrCount);
    end
    while (exp_addr.size() > 0) begin
      logic [4:0] ea, oa;
      ea = exp_addr.pop_front();
      oa = (addr_q.size() > 0) ? addr_q.pop_front() : 5'h1F;
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL pause_fetch_addr got %0d exp %0d", oa, ea); end
    end
    pulse_start();
    checks++;
    if (bus.MemRd !== 1'b1 || bus.MemAddr !== 5'd2) begin
      errors++; $display("FAIL pause_resume got rd=%b addr=%0d exp 1 2", bus.MemRd, bus.MemAddr);
    end
    n = 0;
    while (!(Halted || Error) && n < 200) begin @(negedge Clock); n++; end
    checks++;
    if (Halted !== 1'b1 || InstrCount !== 8'd3) begin
      errors++; $display("FAIL pause_finish got halt=%b cnt=%0d exp 1 3", Halted, InstrCount);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic act;
    do_reset(); mem[0] = 9'h00A; done_en = 1'b0;
    pulse_start();
    n = 0;
    while (!bus.Run && n < 50) begin @(negedge Clock); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL wd_wait_run got timeout exp Run"); end
    // ISSUE sampled here; EXEC is entered two cycles later.
    repeat (9) @(negedge Clock);
    checks++;
    if (Error !== 1'b0) begin errors++; $display("FAIL wd_early got err=%b exp 0", Error); end
    @(negedge Clock);
    checks++;
    if ({Error, Busy, bus.Run, bus.DIN} !== {1'b1, 1'b0, 1'b0, 9'd0}) begin
      errors++;
      $display("FAIL wd_error got err=%b busy=%b run=%b din=%h exp 1 0 0 000", Error, Busy, bus.Run, bus.DIN);
    end
    act = 1'b0;
    pulse_start();
    repeat (5) begin act = act | bus.Run | bus.MemRd | Busy; @(negedge Clock); end
    checks++;
    if (act !== 1'b0 || Error !== 1'b1) begin
      errors++; $display("FAIL wd_start_ignored got activity=%b err=%b exp 0 1", act, Error);
    end
    do_reset();
    checks++;
    if (Error !== 1'b0) begin errors++; $display("FAIL wd_reset_clears got err=%b exp 0", Error); end
    done_en = 1'b1;
  endtask

  task automatic test_mvi_at_end();
    int n, base;
    do_reset();
    for (int i = 0; i < 31; i++) mem31[i] = 9'h00A;
    mem31[31] = 9'h068;
    base = runs31;
    Start31 = 1'b1; @(negedge Clock); Start31 = 1'b0;
    n = 0;
    while (!(Halted31 || Error31) && n < 600) begin @(negedge Clock); n++; end
    @(negedge Clock);
    checks++;
    if ({Error31, Halted31, Busy31} !== {1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL end31_error got err=%b halt=%b busy=%b exp 1 0 0", Error31, Halted31, Busy31);
    end
    checks++;
    if (InstrCount31 !== 8'd31 || (runs31 - base) != 31) begin
      errors++; $display("FAIL end31_count got cnt=%0d runs=%0d exp 31 31", InstrCount31, runs31 - base);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(); load_prog1(); done_en = 1'b1; done_lat = 4;
    pulse_start();
    n = 0;
    while (!bus.Run && n < 50) begin @(negedge Clock); n++; end
    repeat (2) @(negedge Clock);
    checks++;
    if (n >= 50 || Busy !== 1'b1) begin errors++; $display("FAIL mid_reach_exec got busy=%b n=%0d exp 1", Busy, n); end
    Resetn = 1'b1;
    @(negedge Clock);
    Resetn = 1'b0;
    checks++;
    if ({bus.MemAddr, bus.MemRd, bus.DIN, bus.Run, Busy, Halted, Error, InstrCount} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got addr=%h rd=%b din=%h run=%b busy=%b cnt=%0d exp all 0",
               bus.MemAddr, bus.MemRd, bus.DIN, bus.Run, Busy, InstrCount);
    end
    repeat (6) @(negedge Clock);
    checks++;
    if (InstrCount !== 8'd0 || Busy !== 1'b0) begin
      errors++; $display("FAIL mid_late_done got cnt=%0d busy=%b exp 0 0", InstrCount, Busy);
    end
    pulse_start();
    checks++;
    if (bus.MemRd !== 1'b1 || bus.MemAddr !== 5'd0) begin
      errors++; $display("FAIL mid_pc_cleared got rd=%b addr=%0d exp 1 0", bus.MemRd, bus.MemAddr);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mem[i] = '0; mem31[i] = '0; end
    test_reset();
    test_program();
    test_mvi();
    test_pause();
    test_timeout();
    test_mvi_at_end();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
